// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-channel, WIDTH-bit multiplexer with a single registered output
// stage and valid/ready handshakes on both sides.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_data    N packed channels, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel accept strobe (at most one bit high)
//   mode       0 = round-robin arbitration, 1 = fixed select by sel
//   sel        channel index used when mode = 1
//   out_data   registered data of the granted channel
//   out_sel    index of the channel that produced out_data
//   out_valid  out_data/out_sel hold a valid beat
//   out_ready  consumer accepts the beat
module rr_mux_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned SW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SW-1:0]      sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  // One extra bit so ptr + offset (< 2N) can be reduced modulo N.
  localparam int unsigned CW = SW + 1;

  logic [WIDTH-1:0] data_q;
  logic [SW-1:0]    sel_q;
  logic             valid_q;
  logic [SW-1:0]    ptr_q;

  logic             load;
  logic             grant_found;
  logic [SW-1:0]    grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic [SW-1:0]    ptr_next;
  logic [CW-1:0]    cand;

  // Register may take a new beat when empty or being drained this cycle.
  assign load = ~rst & (~valid_q | out_ready);

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    cand        = '0;
    if (mode) begin
      // Comparing against every legal index also rejects sel >= N.
      for (int unsigned i = 0; i < N; i++) begin
        if (sel == SW'(i) && in_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = SW'(i);
          grant_data  = in_data[i*WIDTH +: WIDTH];
        end
      end
    end else begin
      // Scan ptr, ptr+1, ..., wrapping modulo N; first valid channel wins.
      for (int unsigned k = 0; k < N; k++) begin
        cand = {1'b0, ptr_q} + CW'(k);
        if (cand >= CW'(N)) begin
          cand = cand - CW'(N);
        end
        if (!grant_found && in_valid[cand[SW-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = cand[SW-1:0];
        end
      end
      for (int unsigned i = 0; i < N; i++) begin
        if (grant_idx == SW'(i)) begin
          grant_data = in_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (load && grant_found) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // Explicit wrap so non-power-of-two N never reaches an unused index.
  assign ptr_next = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else if (load) begin
      if (grant_found) begin
        data_q  <= grant_data;
        sel_q   <= grant_idx;
        valid_q <= 1'b1;
        if (!mode) begin
          ptr_q <= ptr_next;
        end
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule
